nonce_report_scheduler: RTL and testbench
=========================================

NONCE_REPORT_SCHEDULER -- requirements
Module: nonce_report_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4: number of hash-core requesters (2..8).
REQ-002 Parameter NONCE_BYTES, default 16: nonce length in bytes.
REQ-003 clk_i  in  1  single clock, rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 core_valid_i  in  NUM_CORES  per-core report pending; data held until granted.
REQ-006 core_nonce_i  in  NUM_CORES*NONCE_BYTES*8  flattened nonces, core k at slice k.
REQ-007 core_bits_off_i  in  NUM_CORES*10  flattened bit-distance scores.
REQ-008 core_ready_o  out  NUM_CORES  one-hot, one-cycle grant/consume pulse.
REQ-009 ping_req_i  in  1  one-cycle ping request from the receive path.
REQ-010 reset_ping_waiting_i, reset_nonce_waiting_i, reset_byte_counter_i, decrement_byte_counter_i  in  1 each  transmitter strobes.
REQ-011 send_nonce_o, send_ping_o  out  1 each  waiting flags to transmitter.
REQ-012 nonce_byte_o  out  8  buffered byte selected by byte counter.
REQ-013 nonce_bits_off_o  out  10  buffered score.
REQ-014 byte_counter_zero_o  out  1  byte counter == 0.
REQ-015 best_bits_off_o  out  10  best score accepted so far.

Function
REQ-016 FSM states IDLE, WAIT_TX, STREAM; only IDLE may grant.
REQ-017 IDLE: if any core_valid_i, SHALL pulse core_ready_o for the round-robin winner and capture its nonce and score that same edge.
REQ-018 Round-robin: search starts at pointer; pointer becomes winner+1 mod NUM_CORES after each grant; pointer resets to 0.
REQ-019 Accepted capture: set send_nonce_o, go WAIT_TX next cycle.
REQ-020 WAIT_TX: on reset_nonce_waiting_i, clear send_nonce_o, go STREAM.
REQ-021 reset_byte_counter_i loads counter with NONCE_BYTES-1; decrement_byte_counter_i decrements; counter saturates at 0.
REQ-022 nonce_byte_o = buffer byte [counter]; byte NONCE_BYTES-1 (MSB) sent first; combinational from counter.
REQ-023 STREAM: decrement_byte_counter_i while byte_counter_zero_o returns to IDLE; buffer held stable until then.
REQ-024 Grant-to-send_nonce_o latency: 1 cycle; STREAM-end to next grant: 1 cycle minimum.
REQ-025 send_ping_o set by ping_req_i, cleared by reset_ping_waiting_i; simultaneous set and clear leaves it set.
REQ-026 Ping flag is independent of FSM state; ping_req_i never lost.
REQ-027 Strobes arriving in states where they are meaningless (e.g. reset_nonce_waiting_i in IDLE) SHALL be ignored.

Reset
REQ-028 On rst_n_i low, immediately: state IDLE, core_ready_o 0, send_nonce_o 0, send_ping_o 0, counter 0, buffer 0, pointer 0, best_bits_off_o 10'h3FF.
REQ-029 Reset mid-STREAM SHALL abandon the report; granted core is not re-granted.

Configuration
REQ-030 Macro NONCE_REPORT_BEST_FILTER_EN.
REQ-031 Defined: in IDLE, a granted report with score >= best_bits_off_o is consumed (ready pulsed) and dropped, FSM stays IDLE; score < best is accepted and updates best same edge.
REQ-032 Undefined: every granted report accepted; best_bits_off_o tracks minimum accepted score only.

Structure
REQ-033 Package skein_tx_pkg: FSM state enum, BITS_OFF_W=10, BEST_RESET=10'h3FF.
REQ-034 Sub-module rr_arbiter (request vector, pointer -> one-hot grant, next pointer).

Verification
REQ-035 Single report: core 2 valid, nonce 0x00..0F, score 400 -> ready[2] one cycle, send_nonce_o next cycle, 16 bytes 0x0F..0x00 then IDLE.
REQ-036 All four cores valid at once -> grants 0,1,2,3 in order, each after its STREAM completes.
REQ-037 ping_req_i coincident with reset_ping_waiting_i -> send_ping_o stays 1.
REQ-038 Filter on: scores 500, 600, 300 in sequence -> 500 sent, 600 dropped (ready pulsed, no send), 300 sent, best=300.
REQ-039 rst_n_i low during STREAM byte 5 -> all outputs reset values without clock; next valid core granted from pointer 0.

Source files
------------

// File: rtl/skein_tx_pkg.sv
// -----------------------------------------------------------------------------
// skein_tx_pkg
// Shared types and constants for the nonce report scheduler.
//   tx_state_e  : report FSM state encoding
//   BITS_OFF_W  : width of a bit-distance score
//   BEST_RESET  : "no report seen yet" value of the best-score register
// -----------------------------------------------------------------------------
package skein_tx_pkg;

  localparam int BITS_OFF_W = 10;
  localparam logic [BITS_OFF_W-1:0] BEST_RESET = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_TX = 2'd1,
    ST_STREAM  = 2'd2
  } tx_state_e;

  // Keeps the better (smaller) of two scores.
  function automatic logic [BITS_OFF_W-1:0] min_score(
    input logic [BITS_OFF_W-1:0] a,
    input logic [BITS_OFF_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/nonce_report_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a requester starts
// at ptr_i and wraps; the first set request wins.
// Ports:
//   req_i      : request vector, one bit per requester
//   ptr_i      : index where the search starts (always < N)
//   grant_o    : one-hot grant, all zero when no request
//   winner_o   : index of the granted requester
//   valid_o    : at least one request present
//   next_ptr_o : winner + 1 mod N, pointer value to use after this grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] winner_o,
  output logic             valid_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  always_comb begin : arb
    int unsigned idx;
    grant_o    = '0;
    winner_o   = '0;
    valid_o    = 1'b0;
    next_ptr_o = ptr_i;
    idx        = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = PTR_W'(idx);
        next_ptr_o   = PTR_W'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/nonce_report_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_report_scheduler
// Collects nonce reports from NUM_CORES hash cores (round-robin), buffers one
// report at a time and hands it byte by byte (MSB byte first) to a serial
// transmitter. Also keeps the "ping waiting" flag for the transmitter.
//
// Build option: define NONCE_REPORT_BEST_FILTER_EN to drop any report whose
// score is not strictly better than the best score accepted so far (the core
// is still released with a ready pulse). Without it every report is sent.
//
// Ports:
//   clk_i, rst_n_i             : clock, async active-low reset
//   core_valid_i/_nonce_i/_bits_off_i : per-core report, held until granted
//   core_ready_o               : one-hot grant/consume pulse
//   ping_req_i                 : one-cycle ping request
//   reset_ping_waiting_i, reset_nonce_waiting_i,
//   reset_byte_counter_i, decrement_byte_counter_i : transmitter strobes
//   send_nonce_o, send_ping_o  : waiting flags to transmitter
//   nonce_byte_o               : buffered byte selected by the byte counter
//   nonce_bits_off_o           : buffered score
//   byte_counter_zero_o        : byte counter at zero
//   best_bits_off_o            : best score accepted so far
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no report buffered; arbitrate and capture a core's report
// ST_WAIT_TX | report buffered, send_nonce_o raised, waiting for transmitter
// ST_STREAM  | transmitter reading bytes; ends on decrement at count zero
// -----------------------------------------------------------------------------
module nonce_report_scheduler
  import skein_tx_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int NONCE_BYTES = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_CORES-1:0]              core_valid_i,
  input  logic [NUM_CORES*NONCE_BYTES*8-1:0] core_nonce_i,
  input  logic [NUM_CORES*BITS_OFF_W-1:0]   core_bits_off_i,
  output logic [NUM_CORES-1:0]              core_ready_o,
  input  logic                              ping_req_i,
  input  logic                              reset_ping_waiting_i,
  input  logic                              reset_nonce_waiting_i,
  input  logic                              reset_byte_counter_i,
  input  logic                              decrement_byte_counter_i,
  output logic                              send_nonce_o,
  output logic                              send_ping_o,
  output logic [7:0]                        nonce_byte_o,
  output logic [BITS_OFF_W-1:0]             nonce_bits_off_o,
  output logic                              byte_counter_zero_o,
  output logic [BITS_OFF_W-1:0]             best_bits_off_o
);

  localparam int PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W   = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
  localparam int NONCE_W = NONCE_BYTES * 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NONCE_BYTES - 1);

  tx_state_e                 state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [NUM_CORES-1:0]      ready_q, ready_d;
  logic                      accepted_q, accepted_d;
  logic                      send_nonce_q, send_nonce_d;
  logic                      send_ping_q, send_ping_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NONCE_W-1:0]        buf_q, buf_d;
  logic [BITS_OFF_W-1:0]     bits_q, bits_d;
  logic [BITS_OFF_W-1:0]     best_q, best_d;

  logic [NUM_CORES-1:0]      arb_req;
  logic [NUM_CORES-1:0]      arb_grant;
  logic [PTR_W-1:0]          arb_winner;
  logic                      arb_valid;
  logic [PTR_W-1:0]          arb_next_ptr;
  logic [NONCE_W-1:0]        sel_nonce;
  logic [BITS_OFF_W-1:0]     sel_bits;
  logic                      take_report;

  // A core sees its ready pulse one cycle after capture and drops valid at the
  // following edge; masking it here keeps a dropped report from being granted
  // twice while the core is still lowering valid.
  assign arb_req = core_valid_i & ~ready_q;

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i      (arb_req),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant),
    .winner_o   (arb_winner),
    .valid_o    (arb_valid),
    .next_ptr_o (arb_next_ptr)
  );

  assign sel_nonce = core_nonce_i[int'(arb_winner)*NONCE_W +: NONCE_W];
  assign sel_bits  = core_bits_off_i[int'(arb_winner)*BITS_OFF_W +: BITS_OFF_W];

`ifdef NONCE_REPORT_BEST_FILTER_EN
  assign take_report = (sel_bits < best_q);
`else
  assign take_report = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ready_d      = '0;
    accepted_d   = 1'b0;
    send_nonce_d = send_nonce_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    bits_d       = bits_q;
    best_d       = best_q;

    // Set wins over clear so a ping request is never lost.
    send_ping_d = ping_req_i | (send_ping_q & ~reset_ping_waiting_i);

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          ready_d = arb_grant;
          ptr_d   = arb_next_ptr;
          if (take_report) begin
            buf_d      = sel_nonce;
            bits_d     = sel_bits;
            best_d     = min_score(sel_bits, best_q);
            accepted_d = 1'b1;
            state_d    = ST_WAIT_TX;
          end
        end
      end

      ST_WAIT_TX: begin
        // send_nonce rises the cycle after the grant; a waiting-clear strobe
        // before the flag is up has nothing to acknowledge and is ignored.
        if (accepted_q) begin
          send_nonce_d = 1'b1;
        end else if (send_nonce_q && reset_nonce_waiting_i) begin
          send_nonce_d = 1'b0;
          state_d      = ST_STREAM;
        end
        if (reset_byte_counter_i) begin
          cnt_d = CNT_LAST;
        end
      end

      ST_STREAM: begin
        if (reset_byte_counter_i) begin
          cnt_d = CNT_LAST;
        end else if (decrement_byte_counter_i) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      ready_q      <= '0;
      accepted_q   <= 1'b0;
      send_nonce_q <= 1'b0;
      send_ping_q  <= 1'b0;
      cnt_q        <= '0;
      buf_q        <= '0;
      bits_q       <= '0;
      best_q       <= BEST_RESET;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ready_q      <= ready_d;
      accepted_q   <= accepted_d;
      send_nonce_q <= send_nonce_d;
      send_ping_q  <= send_ping_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      bits_q       <= bits_d;
      best_q       <= best_d;
    end
  end

  assign core_ready_o        = ready_q;
  assign send_nonce_o        = send_nonce_q;
  assign send_ping_o         = send_ping_q;
  assign nonce_byte_o        = buf_q[int'(cnt_q)*8 +: 8];
  assign nonce_bits_off_o    = bits_q;
  assign byte_counter_zero_o = (cnt_q == '0);
  assign best_bits_off_o     = best_q;

endmodule

// File: tb/tb_nonce_report_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nonce_report_scheduler
// Directed bench for nonce_report_scheduler (NUM_CORES=4, NONCE_BYTES=16).
// -----------------------------------------------------------------------------
module tb_nonce_report_scheduler;

  localparam int NC = 4;
  localparam int NB = 16;
`ifdef NONCE_REPORT_BEST_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NC-1:0]     core_valid;
  logic [NC*NB*8-1:0] core_nonce;
  logic [NC*10-1:0]  core_bits;
  logic [NC-1:0]     core_ready;
  logic              ping_req, rst_ping, rst_nonce, rst_cnt, dec_cnt;
  logic              send_nonce, send_ping, cnt_zero;
  logic [7:0]        nonce_byte;
  logic [9:0]        bits_off, best;

  int n_tests = 0;
  int n_fail  = 0;

  nonce_report_scheduler #(.NUM_CORES(NC), .NONCE_BYTES(NB)) dut (
    .clk_i                    (clk),
    .rst_n_i                  (rst_n),
    .core_valid_i             (core_valid),
    .core_nonce_i             (core_nonce),
    .core_bits_off_i          (core_bits),
    .core_ready_o             (core_ready),
    .ping_req_i               (ping_req),
    .reset_ping_waiting_i     (rst_ping),
    .reset_nonce_waiting_i    (rst_nonce),
    .reset_byte_counter_i     (rst_cnt),
    .decrement_byte_counter_i (dec_cnt),
    .send_nonce_o             (send_nonce),
    .send_ping_o              (send_ping),
    .nonce_byte_o             (nonce_byte),
    .nonce_bits_off_o         (bits_off),
    .byte_counter_zero_o      (cnt_zero),
    .best_bits_off_o          (best)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         core;
    logic [7:0] base;
    logic [9:0] score;
    logic [3:0] exp_ready;
    logic [9:0] exp_best;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_core(input int k, input logic [7:0] base, input logic [9:0] score);
    for (int b = 0; b < NB; b++) core_nonce[k*NB*8 + b*8 +: 8] = base + 8'(b);
    core_bits[k*10 +: 10] = score;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for a grant, checks it, then plays the transmitter: reads bytes
  // MSB first. Returns early (mid-stream, counter at stop_at) if stop_at >= 0.
  task automatic serve(input logic [3:0] exp_ready, input logic [7:0] base,
                       input logic [9:0] score, input bit dropped, input int stop_at);
    int waited = 0;
    while (core_ready === '0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (core_ready === '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant expected 0x%0h", exp_ready);
      return;
    end
    chk("grant", 32'(core_ready), 32'(exp_ready));
    chk("send_nonce_before", 32'(send_nonce), 0);
    core_valid = core_valid & ~core_ready;
    @(negedge clk);
    chk("ready_pulse_end", 32'(core_ready), 0);
    if (dropped) begin
      chk("drop_no_send", 32'(send_nonce), 0);
      repeat (3) @(negedge clk);
      chk("drop_no_send_later", 32'(send_nonce), 0);
      return;
    end
    chk("send_nonce", 32'(send_nonce), 1);
    chk("bits_off", 32'(bits_off), 32'(score));
    rst_nonce = 1'b1;
    rst_cnt   = 1'b1;
    @(negedge clk);
    rst_nonce = 1'b0;
    rst_cnt   = 1'b0;
    chk("send_nonce_clr", 32'(send_nonce), 0);
    for (int b = NB - 1; b >= 0; b--) begin
      chk($sformatf("byte%0d", b), 32'(nonce_byte), 32'(base + 8'(b)));
      chk($sformatf("zero%0d", b), 32'(cnt_zero), (b == 0) ? 1 : 0);
      if (b == stop_at) return;
      dec_cnt = 1'b1;
      @(negedge clk);
      dec_cnt = 1'b0;
    end
    chk("stream_end_send", 32'(send_nonce), 0);
    chk("stream_end_zero", 32'(cnt_zero), 1);
  endtask

  initial begin
    rst_n = 1'b1;
    core_valid = '0; core_nonce = '0; core_bits = '0;
    ping_req = 0; rst_ping = 0; rst_nonce = 0; rst_cnt = 0; dec_cnt = 0;

    tbl[0] = '{core: 2, base: 8'h00, score: 10'd400, exp_ready: 4'b0100, exp_best: 10'd400};
    tbl[1] = '{core: 0, base: 8'h40, score: 10'd350, exp_ready: 4'b0001, exp_best: 10'd350};
    tbl[2] = '{core: 3, base: 8'hA0, score: 10'd200, exp_ready: 4'b1000, exp_best: 10'd200};
    tbl[3] = '{core: 1, base: 8'h10, score: 10'd100, exp_ready: 4'b0010, exp_best: 10'd100};

    // Asynchronous reset values, sampled with no clock edge since assertion.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(core_ready), 0);
    chk("rst_send_nonce", 32'(send_nonce), 0);
    chk("rst_send_ping", 32'(send_ping), 0);
    chk("rst_zero", 32'(cnt_zero), 1);
    chk("rst_byte", 32'(nonce_byte), 0);
    chk("rst_bits", 32'(bits_off), 0);
    chk("rst_best", 32'(best), 32'h3FF);
    @(negedge clk);
    rst_n = 1'b1;

    // Transmitter strobes in IDLE do nothing.
    rst_cnt = 1; rst_nonce = 1;
    @(negedge clk);
    rst_cnt = 0; rst_nonce = 0;
    chk("idle_ignore_cnt", 32'(cnt_zero), 1);
    chk("idle_ignore_nonce", 32'(send_nonce), 0);

    // All four cores at once: served 0,1,2,3 in order.
    set_core(0, 8'h00, 10'd900);
    set_core(1, 8'h20, 10'd800);
    set_core(2, 8'h50, 10'd700);
    set_core(3, 8'h80, 10'd600);
    core_valid = 4'b1111;
    serve(4'b0001, 8'h00, 10'd900, 0, -1);
    serve(4'b0010, 8'h20, 10'd800, 0, -1);
    serve(4'b0100, 8'h50, 10'd700, 0, -1);
    serve(4'b1000, 8'h80, 10'd600, 0, -1);
    chk("all4_best", 32'(best), 32'd600);

    // Table of single reports, descending scores so every build accepts them.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_core(tbl[i].core, tbl[i].base, tbl[i].score);
      core_valid[tbl[i].core] = 1'b1;
      serve(tbl[i].exp_ready, tbl[i].base, tbl[i].score, 0, -1);
      chk($sformatf("tbl%0d_best", i), 32'(best), 32'(tbl[i].exp_best));
    end

    // Ping flag.
    ping_req = 1;
    @(negedge clk);
    ping_req = 0;
    chk("ping_set", 32'(send_ping), 1);
    @(negedge clk);
    chk("ping_hold", 32'(send_ping), 1);
    ping_req = 1; rst_ping = 1;
    @(negedge clk);
    ping_req = 0; rst_ping = 0;
    chk("ping_set_and_clr", 32'(send_ping), 1);
    rst_ping = 1;
    @(negedge clk);
    rst_ping = 0;
    chk("ping_clr", 32'(send_ping), 0);

    // Scores 500, 600, 300 from core 0.
    do_reset();
    set_core(0, 8'h60, 10'd500);
    core_valid = 4'b0001;
    serve(4'b0001, 8'h60, 10'd500, 0, -1);
    chk("seq_best_500", 32'(best), 32'd500);
    set_core(0, 8'h70, 10'd600);
    core_valid = 4'b0001;
    serve(4'b0001, 8'h70, 10'd600, FILTER, -1);
    chk("seq_best_600", 32'(best), 32'd500);
    set_core(0, 8'h90, 10'd300);
    core_valid = 4'b0001;
    serve(4'b0001, 8'h90, 10'd300, 0, -1);
    chk("seq_best_300", 32'(best), 32'd300);

    // Reset in the middle of a stream, with a ping pending.
    ping_req = 1;
    @(negedge clk);
    ping_req = 0;
    set_core(1, 8'h30, 10'd250);
    core_valid = 4'b0010;
    serve(4'b0010, 8'h30, 10'd250, 0, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(core_ready), 0);
    chk("mid_rst_send_nonce", 32'(send_nonce), 0);
    chk("mid_rst_send_ping", 32'(send_ping), 0);
    chk("mid_rst_zero", 32'(cnt_zero), 1);
    chk("mid_rst_byte", 32'(nonce_byte), 0);
    chk("mid_rst_bits", 32'(bits_off), 0);
    chk("mid_rst_best", 32'(best), 32'h3FF);
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer back at 0: core 1 beats core 3.
    set_core(3, 8'hC0, 10'd120);
    core_valid = 4'b1010;
    serve(4'b0010, 8'h30, 10'd250, 0, -1);
    serve(4'b1000, 8'hC0, 10'd120, 0, -1);
    chk("post_rst_best", 32'(best), 32'd120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
